// File: rtl/led_bank_ctrl_pkg.sv
// rtl/led_bank_ctrl_pkg.sv - shared register map and reset values for led_bank_ctrl
package led_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    ADDR_LEDVAL   = 2'd0,
    ADDR_BLINKEN  = 2'd1,
    ADDR_DUTY     = 2'd2,
    ADDR_BLINKDIV = 2'd3
  } reg_addr_e;

  // Sliced down to the configured widths at the point of use
  localparam logic [31:0] RST_LEDVAL      = 32'h0000_0000;
  localparam logic [31:0] RST_BLINKEN     = 32'h0000_0000;
  localparam logic [31:0] RST_DUTY        = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_BLINKDIV    = 32'h0000_0000;
  localparam logic        RST_BLINK_PHASE = 1'b1;

endpackage

// File: rtl/led_bank_ctrl_if.sv
// rtl/led_bank_ctrl_if.sv - CPU word-register bus for led_bank_ctrl
interface led_bank_ctrl_if;
  logic [1:0]  addr;
  logic [31:0] din;
  logic        WE;
  logic [31:0] RD;

  modport master (output addr, output din, output WE, input RD);
  modport slave  (input addr, input din, input WE, output RD);
endinterface

// File: rtl/led_bank_ctrl_timebase.sv
// rtl/led_bank_ctrl_timebase.sv - free-running PWM counter and blink prescaler
module led_timebase
  import led_bank_ctrl_pkg::*;
#(
  parameter int PWM_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PWM_W-1:0] duty,
  input  logic [DIV_W-1:0] blinkdiv,
  input  logic             div_clear,
  output logic             pwm_on,
  output logic             blink_phase
);

  localparam logic [PWM_W-1:0] PWM_ONE = PWM_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [PWM_W-1:0] r_pwm_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
  end

  // A divider write restarts the half-period even on a terminal-count edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_blink_phase <= RST_BLINK_PHASE;
    end else if (div_clear || blinkdiv == '0) begin
      r_div_cnt     <= '0;
      r_blink_phase <= 1'b1;
    end else if (r_div_cnt == blinkdiv) begin
      r_div_cnt     <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_div_cnt     <= r_div_cnt + DIV_ONE;
    end
  end

  assign pwm_on      = (&duty) | (r_pwm_cnt < duty);
  assign blink_phase = r_blink_phase;

endmodule

// File: rtl/led_bank_ctrl.sv
// rtl/led_bank_ctrl.sv - LED bank with per-LED value/blink, global PWM and registered pins
module led_bank_ctrl
  import led_bank_ctrl_pkg::*;
#(
  parameter int N_LED = 32,
  parameter int PWM_W = 8,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  led_bank_ctrl_if.slave    bus,
  output logic [N_LED-1:0]  led_light
);

  logic [N_LED-1:0] r_ledval;
  logic [N_LED-1:0] r_blinken;
  logic [PWM_W-1:0] r_duty;
  logic [DIV_W-1:0] r_blinkdiv;
  logic [N_LED-1:0] r_led_light;

  logic             w_wr_div;
  logic             w_pwm_on;
  logic             w_blink_phase;
  logic [N_LED-1:0] w_led_next;

  assign w_wr_div = bus.WE && (bus.addr == ADDR_BLINKDIV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ledval   <= RST_LEDVAL[N_LED-1:0];
      r_blinken  <= RST_BLINKEN[N_LED-1:0];
      r_duty     <= RST_DUTY[PWM_W-1:0];
      r_blinkdiv <= RST_BLINKDIV[DIV_W-1:0];
    end else if (bus.WE) begin
      case (bus.addr)
        ADDR_LEDVAL:   r_ledval   <= bus.din[N_LED-1:0];
        ADDR_BLINKEN:  r_blinken  <= bus.din[N_LED-1:0];
        ADDR_DUTY:     r_duty     <= bus.din[PWM_W-1:0];
        ADDR_BLINKDIV: r_blinkdiv <= bus.din[DIV_W-1:0];
        default:       r_ledval   <= r_ledval;
      endcase
    end
  end

  led_timebase #(
    .PWM_W (PWM_W),
    .DIV_W (DIV_W)
  ) u_timebase (
    .clk         (clk),
    .reset       (reset),
    .duty        (r_duty),
    .blinkdiv    (r_blinkdiv),
    .div_clear   (w_wr_div),
    .pwm_on      (w_pwm_on),
    .blink_phase (w_blink_phase)
  );

  always_comb begin
    bus.RD = '0;
    case (bus.addr)
      ADDR_LEDVAL:   bus.RD[N_LED-1:0] = r_ledval;
      ADDR_BLINKEN:  bus.RD[N_LED-1:0] = r_blinken;
      ADDR_DUTY:     bus.RD[PWM_W-1:0] = r_duty;
      ADDR_BLINKDIV: bus.RD[DIV_W-1:0] = r_blinkdiv;
      default:       bus.RD = '0;
    endcase
  end

  assign w_led_next = r_ledval & {N_LED{w_pwm_on}} & (~r_blinken | {N_LED{w_blink_phase}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_led_light <= '0;
    else       r_led_light <= w_led_next;
  end

  assign led_light = r_led_light;

endmodule

// File: doc/led_bank_ctrl.md
Name: led_bank_ctrl

Overview:
- Parametrised LED output peripheral on the CPU bus; successor to the single 32-bit LED latch.
- Holds a per-LED on/off value register, plus:
  - per-LED blink enable;
  - global PWM brightness;
  - programmable blink period.
- Exposes four word registers selected by a 2-bit word address; readback is combinational.
- Drives the board LED pins through a registered output stage.

Parameters:
- N_LED, 32, number of LED channels (1..32).
- PWM_W, 8, PWM counter/duty width in bits (1..16).
- DIV_W, 16, blink prescaler width in bits (1..32).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- addr  input  2  register word select: 0 LEDVAL, 1 BLINKEN, 2 DUTY, 3 BLINKDIV.
- din  input  32  write data.
- WE  input  1  write enable, sampled on posedge clk.
- RD  output  32  read data for addr, combinational.
- led_light  output  N_LED  registered LED drive, 1 = lit.

Behaviour:
- Reset is asynchronous, active-high. All state clears immediately; release is taken at the next clk edge. Reset values:
  - LEDVAL=0, BLINKEN=0.
  - DUTY=all ones (full brightness).
  - BLINKDIV=0 (blink disabled).
  - pwm_cnt=0, div_cnt=0, blink_phase=1.
  - led_light=0.
- Writes take effect on posedge clk when WE=1. Register destination is din[width-1:0]; upper din bits are ignored.
  - addr 0 → LEDVAL[N_LED-1:0].
  - addr 1 → BLINKEN[N_LED-1:0].
  - addr 2 → DUTY[PWM_W-1:0].
  - addr 3 → BLINKDIV[DIV_W-1:0]. This write also clears div_cnt and sets blink_phase=1 in the same edge.
- RD = selected register zero-extended to 32 bits. Reading has no side effects. A write is visible on RD the cycle after the edge.
- PWM:
  - pwm_cnt increments every cycle and wraps from 2^PWM_W-1 to 0.
  - pwm_on = (DUTY == all ones) OR (pwm_cnt < DUTY).
  - DUTY=0 → always off. All ones → always on, not (2^PWM_W-1)/2^PWM_W.
- Blink:
  - If BLINKDIV==0: div_cnt holds 0 and blink_phase holds 1.
  - Else div_cnt increments each cycle. When div_cnt == BLINKDIV, div_cnt←0 and blink_phase toggles.
  - Half-period is therefore BLINKDIV+1 cycles.
- Output: next led_light[i] = LEDVAL[i] & pwm_on & (~BLINKEN[i] | blink_phase).
  - led_light is registered: one cycle latency from the register/counter values to the pins.
  - After a LEDVAL write at edge k, the pin reflects it at edge k+1.
- Simultaneous events:
  - A BLINKDIV write on the same edge as a terminal count: the write wins (div_cnt=0, phase=1).
  - Reset asserted mid-blink or mid-PWM: immediate return to reset values, including led_light=0.
- No FIFO or handshake: WE is single-cycle and always accepted; back-to-back writes to any addresses are legal.

Decomposition:
- Shared package holds:
  - register address constants ADDR_LEDVAL=0, ADDR_BLINKEN=1, ADDR_DUTY=2, ADDR_BLINKDIV=3;
  - reset-value constants.
- One sub-module: led_timebase (params PWM_W, DIV_W).
  - Inputs: clk, reset, duty, blinkdiv, div_clear.
  - Outputs: pwm_on, blink_phase.
  - Contains pwm_cnt and div_cnt.
- Top keeps registers, read mux and output register.

Test Plan:
- Reset/readback: assert reset mid-run with LEDVAL=0xFFFF → led_light=0 immediately. After release, RD reads 0, 0, 0x000000FF, 0 for addr 0..3.
- Static write: WE addr0 din=0xA5A5A5A5, DUTY default → RD(addr0)=0xA5A5A5A5 next cycle; led_light=0xA5A5A5A5 one edge after the write.
- PWM duty: LEDVAL=1, DUTY=64, PWM_W=8 → led_light[0] high exactly 64 of every 256 cycles. DUTY=0 → never high. DUTY=255 → always high.
- Blink: LEDVAL=0x3, BLINKEN=0x1, BLINKDIV=4 → bit0 toggles every 5 cycles and starts high after the write; bit1 stays high.
- Blink restart: write BLINKDIV=9 while blink_phase=0 mid-count → phase=1 and div_cnt=0 on that edge. First toggle comes 10 cycles later.
- Width truncation (N_LED=8 build): write din=0xFFFF_FF3C to addr0 → RD=0x0000003C, led_light=0x3C.
